// File: rtl/alu_decode_stage_pkg.sv
// Shared encodings for the ALU decode stage: ALU control codes, opcodes, operand selects
// and the decoded bundle carried through the output register and skid buffer.
package alu_decode_stage_pkg;

    localparam logic [3:0] ALUCTL_ADD  = 4'd0;
    localparam logic [3:0] ALUCTL_SUB  = 4'd1;
    localparam logic [3:0] ALUCTL_SLL  = 4'd2;
    localparam logic [3:0] ALUCTL_SLT  = 4'd3;
    localparam logic [3:0] ALUCTL_SLTU = 4'd4;
    localparam logic [3:0] ALUCTL_XOR  = 4'd5;
    localparam logic [3:0] ALUCTL_SRL  = 4'd6;
    localparam logic [3:0] ALUCTL_SRA  = 4'd7;
    localparam logic [3:0] ALUCTL_OR   = 4'd8;
    localparam logic [3:0] ALUCTL_AND  = 4'd9;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [1:0] A_SEL_RS1  = 2'd0;
    localparam logic [1:0] A_SEL_PC   = 2'd1;
    localparam logic [1:0] A_SEL_ZERO = 2'd2;

    localparam logic B_SEL_RS2 = 1'b0;
    localparam logic B_SEL_IMM = 1'b1;

    typedef struct packed {
        logic [3:0]  alu_ctl;
        logic [1:0]  a_sel;
        logic        b_sel;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rd_we;
        logic        illegal;
        logic [31:0] pc;
    } decoded_t;

endpackage

// File: rtl/alu_decode_stage_alu_ctl_decoder.sv
// Combinational RV32I decoder for OP, OP-IMM, LUI and AUIPC into an ALU control bundle.
module alu_ctl_decoder
    import alu_decode_stage_pkg::*;
(
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    output decoded_t    dec_o
);

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       illegal;

    assign opcode = instr_i[6:0];
    assign f3     = instr_i[14:12];
    assign f7     = instr_i[31:25];

    function automatic logic [3:0] base_op(input logic [2:0] funct3, input logic alt);
        case (funct3)
            3'b000:  base_op = alt ? ALUCTL_SUB : ALUCTL_ADD;
            3'b001:  base_op = ALUCTL_SLL;
            3'b010:  base_op = ALUCTL_SLT;
            3'b011:  base_op = ALUCTL_SLTU;
            3'b100:  base_op = ALUCTL_XOR;
            3'b101:  base_op = alt ? ALUCTL_SRA : ALUCTL_SRL;
            3'b110:  base_op = ALUCTL_OR;
            default: base_op = ALUCTL_AND;
        endcase
    endfunction

    always_comb begin
        dec_o         = '0;
        dec_o.a_sel   = A_SEL_RS1;
        dec_o.b_sel   = B_SEL_RS2;
        dec_o.imm     = {{20{instr_i[31]}}, instr_i[31:20]};
        dec_o.rs1     = instr_i[19:15];
        dec_o.rs2     = instr_i[24:20];
        dec_o.rd      = instr_i[11:7];
        dec_o.pc      = pc_i;
        dec_o.alu_ctl = ALUCTL_ADD;
        illegal       = 1'b0;

        case (opcode)
            OPC_OP_IMM: begin
                dec_o.b_sel = B_SEL_IMM;
                // funct7 only qualifies the shift forms; for arithmetic it is part of the immediate
                if (f3 == 3'b001 && f7 != F7_BASE)
                    illegal = 1'b1;
                if (f3 == 3'b101 && f7 != F7_BASE && f7 != F7_ALT)
                    illegal = 1'b1;
                dec_o.alu_ctl = base_op(f3, (f3 == 3'b101) && (f7 == F7_ALT));
            end
            OPC_OP: begin
                if (!(f7 == F7_BASE || (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101))))
                    illegal = 1'b1;
                dec_o.alu_ctl = base_op(f3, f7 == F7_ALT);
            end
            OPC_LUI: begin
                dec_o.a_sel = A_SEL_ZERO;
                dec_o.b_sel = B_SEL_IMM;
                dec_o.imm   = {instr_i[31:12], 12'b0};
            end
            OPC_AUIPC: begin
                dec_o.a_sel = A_SEL_PC;
                dec_o.b_sel = B_SEL_IMM;
                dec_o.imm   = {instr_i[31:12], 12'b0};
            end
            default: illegal = 1'b1;
        endcase

        if (illegal)
            dec_o.alu_ctl = ALUCTL_ADD;
        dec_o.illegal = illegal;
        dec_o.rd_we   = !illegal && (dec_o.rd != 5'd0);
    end

endmodule

// File: rtl/alu_decode_stage.sv
// Decode stage: valid/ready handshake into a registered decoded bundle backed by a one-entry skid.
module alu_decode_stage
    import alu_decode_stage_pkg::*;
#(
    parameter bit SKID_EN   = 1'b1,
    parameter bit FLAG_ONLY = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_alu_ctl,
    output logic [1:0]  out_a_sel,
    output logic        out_b_sel,
    output logic [31:0] out_imm,
    output logic [4:0]  out_rs1,
    output logic [4:0]  out_rs2,
    output logic [4:0]  out_rd,
    output logic        out_rd_we,
    output logic        out_illegal,
    output logic [31:0] out_pc
);

    decoded_t dec;
    decoded_t out_q, out_d;
    decoded_t skid_q, skid_d;
    logic     out_valid_q, out_valid_d;
    logic     skid_full_q, skid_full_d;
    logic     in_ready_q;
    logic     accept;

    alu_ctl_decoder u_decoder (
        .instr_i (in_instr),
        .pc_i    (in_pc),
        .dec_o   (dec)
    );

    assign in_ready = SKID_EN ? in_ready_q : (out_ready | ~out_valid_q);
    assign accept   = in_valid & in_ready & ~flush;

    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        skid_d      = skid_q;
        skid_full_d = skid_full_q;

        if (flush) begin
            out_valid_d = 1'b0;
            skid_full_d = 1'b0;
        end else if (skid_full_q) begin
            // in_ready is low here, so only the skid entry can advance
            if (out_ready) begin
                out_d       = skid_q;
                out_valid_d = 1'b1;
                skid_full_d = 1'b0;
            end
        end else if (!out_valid_q || out_ready) begin
            out_valid_d = accept;
            if (accept)
                out_d = dec;
        end else if (accept) begin
            skid_d      = dec;
            skid_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q       <= '0;
            skid_q      <= '0;
            out_valid_q <= 1'b0;
            skid_full_q <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            out_q       <= out_d;
            skid_q      <= skid_d;
            out_valid_q <= out_valid_d;
            skid_full_q <= skid_full_d;
            in_ready_q  <= ~skid_full_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_alu_ctl = out_q.alu_ctl;
    assign out_a_sel   = out_q.a_sel;
    assign out_b_sel   = out_q.b_sel;
    assign out_imm     = out_q.imm;
    assign out_rs1     = out_q.rs1;
    assign out_rs2     = out_q.rs2;
    assign out_rd      = out_q.rd;
    assign out_rd_we   = out_q.rd_we;
    // Both modes emit the flagged bundle unchanged
    assign out_illegal = FLAG_ONLY ? out_q.illegal : out_q.illegal;
    assign out_pc      = out_q.pc;

endmodule
